// File: rtl/note_sequencer.sv
// Song ROM walker driving the note decoder: timed notes, articulation gaps, end marker.
// Optional NOTE_SEQ_LOOP_EN: restart from entry 0 at end of song instead of idling.
module note_sequencer #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned GAP_TICKS = 20,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] song_addr,
  input  logic [15:0]       song_data,
  output logic [9:0]        note,
  output logic              note_gate,
  output logic              playing,
  output logic              done
);

  localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_CW  = $clog2(GAP_TICKS + 1);
  localparam int unsigned TICK_W  = (GAP_CW > 6) ? GAP_CW : 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [9:0]          note_d;
  logic                gate_d;
  logic                done_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                tick_wrap;
  logic                end_song;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      song_addr <= '0;
      note      <= '0;
      note_gate <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
      pre_q     <= '0;
      tick_q    <= '0;
    end else begin
      state_q   <= state_d;
      song_addr <= addr_d;
      note      <= note_d;
      note_gate <= gate_d;
      playing   <= (state_d != S_IDLE);
      done      <= done_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = song_addr;
    note_d    = note;
    gate_d    = note_gate;
    done_d    = 1'b0;
    pre_d     = pre_q;
    tick_d    = tick_q;
    end_song  = 1'b0;
    tick_wrap = (pre_q == PRE_W'(TICK_DIV - 1));

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (song_data[5:0] == 6'd0) begin
          end_song = 1'b1;
        end else begin
          note_d  = song_data[15:6];
          gate_d  = |song_data[15:6];
          tick_d  = TICK_W'(song_data[5:0]);
          pre_d   = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY, S_GAP: begin
        if (!tick_wrap) begin
          pre_d = pre_q + PRE_W'(1);
        end else begin
          pre_d = '0;
          if (tick_q != TICK_W'(1)) begin
            tick_d = tick_q - TICK_W'(1);
          end else if (state_q == S_PLAY) begin
            gate_d  = 1'b0;
            tick_d  = TICK_W'(GAP_TICKS);
            state_d = S_GAP;
          end else if (song_addr == {ADDR_W{1'b1}}) begin
            end_song = 1'b1;
          end else begin
            addr_d  = song_addr + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Marker and address wrap share one end-of-song path
    if (end_song) begin
      done_d = 1'b1;
      note_d = '0;
      gate_d = 1'b0;
      addr_d = '0;
`ifdef NOTE_SEQ_LOOP_EN
      state_d = S_FETCH;
`else
      state_d = S_IDLE;
`endif
    end

    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      note_d  = '0;
      gate_d  = 1'b0;
      addr_d  = '0;
      done_d  = 1'b0;
    end
  end

endmodule
